bus_copy_master: RTL and testbench
==================================

BUS_COPY_MASTER -- requirements
Module: bus_copy_master

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum cycles to wait for ack on one bus transaction.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  copy request; sampled only in IDLE.
REQ-005 src_adr  input  30  word address of the first source word, bits [31:2].
REQ-006 dst_adr  input  30  word address of the first destination word, bits [31:2].
REQ-007 len  input  16  number of 32-bit words to copy.
REQ-008 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-009 done  output  1  one-cycle pulse when a copy completes or aborts.
REQ-010 err  output  1  sticky timeout flag; cleared by the next accepted start.
REQ-011 adr  output  30  bus word address, bits [31:2].
REQ-012 dat  output  32  bus write data.
REQ-013 sel  output  4  byte enables.
REQ-014 we  output  1  bus write strobe.
REQ-015 cyc  output  1  bus cycle valid.
REQ-016 rdt  input  32  bus read data; valid in the cycle where ack=1.
REQ-017 ack  input  1  responder acknowledge; a single-cycle pulse per transaction.

Function
REQ-018 FSM states: IDLE, READ, WRITE, DONE.
REQ-019 IDLE: when start=1, latch src_adr, dst_adr and len, clear err, go to READ; if len=0, go directly to DONE with no bus activity.
REQ-020 READ: cyc=1, we=0, sel=4'hF, adr=current source pointer; hold all four stable until ack=1 is sampled.
REQ-021 On ack in READ: capture rdt into the data register, increment the source pointer, go to WRITE.
REQ-022 WRITE: cyc=1, we=1, sel=4'hF, adr=current destination pointer, dat=captured word; hold until ack=1 is sampled.
REQ-023 On ack in WRITE: increment the destination pointer and decrement the remaining count; if the count reaches 0 go to DONE, else go to READ.
REQ-024 Back-to-back transactions are allowed: cyc may stay high across a READ->WRITE or WRITE->READ transition, with adr, we and dat changed on the same edge.
REQ-025 Read latency per transaction is the responder's ack latency; the block adds no wait cycles between transactions.
REQ-026 Pointers are 30-bit and increment modulo 2^30 (3FFFFFFF wraps to 00000000); no error is raised on wrap.
REQ-027 Watchdog counter: cleared on entry to READ or WRITE, increments each cycle while waiting for ack.
REQ-028 Watchdog expiry: on reaching TIMEOUT without ack, set err=1, drop cyc and we, go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, cyc=0, we=0, then go to IDLE.
REQ-030 While busy, start is ignored and latched parameters do not change.
REQ-031 An ack sampled while cyc=0 is ignored.

Reset
REQ-032 When resetn=0 at a rising edge: state=IDLE, cyc=0, we=0, sel=0, adr=0, dat=0, busy=0, done=0, err=0, count and watchdog cleared.
REQ-033 Reset mid-transfer aborts immediately: cyc drops on the reset edge and no done pulse is issued.

Structure
REQ-034 A shared package holds the state enum, SEL_ALL=4'hF and the default TIMEOUT value.
REQ-035 The watchdog is a sub-module, bus_watchdog, with inputs clear and run, a TIMEOUT parameter and an expired output.

Verification
REQ-036 Responder acks one cycle after cyc; src=0x100, dst=0x200, len=4, mem[0x100..0x103]=A0..A3 -> mem[0x200..0x203]=A0..A3, 8 acked transactions, one done pulse, err=0.
REQ-037 start with len=0 -> done pulse on the second cycle after start, cyc never asserted.
REQ-038 Responder never acks on the first read, TIMEOUT=16 -> cyc drops after 16 wait cycles, err=1, one done pulse; the next start clears err.
REQ-039 src=0x3FFFFFFF, len=2 -> reads from 0x3FFFFFFF then 0x00000000.
REQ-040 resetn pulsed low during the second WRITE of a len=4 copy -> cyc=0 and busy=0 the next cycle, no done pulse, and a new start copies correctly.
REQ-041 start pulsed repeatedly while busy -> the transfer is unchanged and exactly one done pulse is issued.

Source files
------------

// File: rtl/bus_copy_master_pkg.sv
// Shared types and constants for the bus copy master and its watchdog.
package bus_copy_master_pkg;

  localparam int unsigned ADR_W           = 30;
  localparam int unsigned DAT_W           = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned LEN_W           = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             cyc;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } bus_req_t;

  // Word pointers wrap silently at the top of the 30-bit space.
  function automatic logic [ADR_W-1:0] next_word(input logic [ADR_W-1:0] a);
    return a + ADR_W'(1);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles spent waiting for an acknowledge and flags expiry at TIMEOUT.
module bus_watchdog
  import bus_copy_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // expired rises while the TIMEOUT-th wait cycle is in progress, so the
  // master can abort on the edge that would complete that cycle.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (run) begin
      count   <= count + CNT_W'(1);
      expired <= expired | (count == CNT_W'(TIMEOUT - 2));
    end
  end

endmodule

// File: rtl/bus_copy_master.sv
// Word-by-word memory copy master: read a source word, write it to the
// destination, repeat len times, with a per-transaction ack watchdog.
module bus_copy_master
  import bus_copy_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [ADR_W-1:0]    src_adr,
  input  logic [ADR_W-1:0]    dst_adr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADR_W-1:0]    adr,
  output logic [DAT_W-1:0]    dat,
  output logic [SEL_W-1:0]    sel,
  output logic                we,
  output logic                cyc,
  input  logic [DAT_W-1:0]    rdt,
  input  logic                ack
);

  state_t           state, state_nxt;
  bus_req_t         bus, bus_nxt;
  logic [ADR_W-1:0] src_ptr, src_ptr_nxt;
  logic [ADR_W-1:0] dst_ptr, dst_ptr_nxt;
  logic [LEN_W-1:0] remain, remain_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             wd_clear, wd_run, wd_expired;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      bus     <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      remain  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus     <= bus_nxt;
      src_ptr <= src_ptr_nxt;
      dst_ptr <= dst_ptr_nxt;
      remain  <= remain_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  // Next-state and next-output logic; every register is updated from here.
  always_comb begin
    state_nxt   = state;
    bus_nxt     = bus;
    src_ptr_nxt = src_ptr;
    dst_ptr_nxt = dst_ptr;
    remain_nxt  = remain;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;
    wd_clear    = 1'b0;
    wd_run      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          err_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          src_ptr_nxt = src_adr;
          dst_ptr_nxt = dst_adr;
          remain_nxt  = len;
          if (len == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt   = ST_READ;
            wd_clear    = 1'b1;
            bus_nxt.cyc = 1'b1;
            bus_nxt.we  = 1'b0;
            bus_nxt.sel = SEL_ALL;
            bus_nxt.adr = src_adr;
          end
        end
      end

      ST_READ: begin
        if (ack) begin
          // cyc stays high: the write is issued on the same edge.
          state_nxt   = ST_WRITE;
          wd_clear    = 1'b1;
          src_ptr_nxt = next_word(src_ptr);
          bus_nxt.we  = 1'b1;
          bus_nxt.adr = dst_ptr;
          bus_nxt.dat = rdt;
        end else if (wd_expired) begin
          state_nxt   = ST_DONE;
          err_nxt     = 1'b1;
          bus_nxt.cyc = 1'b0;
          bus_nxt.we  = 1'b0;
          bus_nxt.sel = '0;
        end else begin
          wd_run = 1'b1;
        end
      end

      ST_WRITE: begin
        if (ack) begin
          dst_ptr_nxt = next_word(dst_ptr);
          remain_nxt  = remain - LEN_W'(1);
          if (remain == LEN_W'(1)) begin
            state_nxt   = ST_DONE;
            bus_nxt.cyc = 1'b0;
            bus_nxt.we  = 1'b0;
            bus_nxt.sel = '0;
          end else begin
            state_nxt   = ST_READ;
            wd_clear    = 1'b1;
            bus_nxt.we  = 1'b0;
            bus_nxt.adr = src_ptr;
          end
        end else if (wd_expired) begin
          state_nxt   = ST_DONE;
          err_nxt     = 1'b1;
          bus_nxt.cyc = 1'b0;
          bus_nxt.we  = 1'b0;
          bus_nxt.sel = '0;
        end else begin
          wd_run = 1'b1;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cyc = bus.cyc;
  assign we  = bus.we;
  assign sel = bus.sel;
  assign adr = bus.adr;
  assign dat = bus.dat;

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master with a one-cycle-latency responder model.
module tb_bus_copy_master;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [29:0] src_adr, dst_adr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc;
  logic [31:0] rdt;
  logic        ack;

  logic        no_ack;
  int          n_tests;
  int          n_fail;
  int          cyc_cycles;
  int          ack_cnt;
  int          done_cnt;
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  bus_copy_master #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .src_adr (src_adr),
    .dst_adr (dst_adr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .adr     (adr),
    .dat     (dat),
    .sel     (sel),
    .we      (we),
    .cyc     (cyc),
    .rdt     (rdt),
    .ack     (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: single-cycle ack one cycle after cyc; read data = A0000000 | adr.
  always @(posedge clk) begin
    if (!resetn || !cyc || ack || no_ack) begin
      ack <= 1'b0;
    end else begin
      ack <= 1'b1;
      rdt <= 32'hA000_0000 | {2'b00, adr};
    end
  end

  // Bus monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (cyc) cyc_cycles++;
    if (done) done_cnt++;
    if (cyc && ack) begin
      ack_cnt++;
      if (we) begin
        wa_q.push_back({2'b00, adr});
        wd_q.push_back(dat);
      end else begin
        rd_q.push_back({2'b00, adr});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_stats();
    @(posedge clk);
    #1;
    cyc_cycles = 0;
    ack_cnt    = 0;
    done_cnt   = 0;
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic issue(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n);
    clear_stats();
    @(negedge clk);
    src_adr = s;
    dst_adr = d;
    len     = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_copy(input string tag, input logic [29:0] s, input logic [29:0] d, input int n);
    check({tag, "_writes"}, wa_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_wadr"}, q_at(wa_q, i), {2'b00, d} + i);
      check({tag, "_wdat"}, q_at(wd_q, i), 32'hA000_0000 | ({2'b00, s} + i));
    end
  endtask

  initial begin
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    no_ack  = 1'b0;
    resetn  = 1'b0;
    start   = 1'b0;
    src_adr = '0;
    dst_adr = '0;
    len     = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc",  {31'd0, cyc},  32'd0);
    check("rst_we",   {31'd0, we},   32'd0);
    check("rst_sel",  {28'd0, sel},  32'd0);
    check("rst_adr",  {2'b00, adr},  32'd0);
    check("rst_dat",  dat,           32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Four-word copy with a one-cycle responder.
    issue(30'h100, 30'h200, 16'd4);
    check("copy_busy", {31'd0, busy}, 32'd1);
    wait_done("copy", 100);
    check_copy("copy", 30'h100, 30'h200, 4);
    check("copy_acks", ack_cnt, 32'd8);
    check("copy_cyc_cycles", cyc_cycles, 32'd16);
    check("copy_dones", done_cnt, 32'd1);
    check("copy_err", {31'd0, err}, 32'd0);
    check("copy_idle_busy", {31'd0, busy}, 32'd0);

    // len=0: done on the second cycle after start, no bus activity.
    clear_stats();
    @(negedge clk);
    src_adr = 30'h123;
    dst_adr = 30'h234;
    len     = 16'd0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check("len0_c1_done", {31'd0, done}, 32'd0);
    check("len0_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("len0_c2_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("len0_c3_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("len0_cyc_cycles", cyc_cycles, 32'd0);
    check("len0_dones", done_cnt, 32'd1);

    // Watchdog: no ack on the first read.
    no_ack = 1'b1;
    issue(30'h100, 30'h200, 16'd2);
    wait_done("tmo", 100);
    no_ack = 1'b0;
    check("tmo_cyc_cycles", cyc_cycles, 32'd16);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_dones", done_cnt, 32'd1);
    check("tmo_writes", wa_q.size(), 32'd0);
    issue(30'h1F0, 30'h2F0, 16'd1);
    check("tmo_err_cleared", {31'd0, err}, 32'd0);
    wait_done("tmo_next", 100);
    check_copy("tmo_next", 30'h1F0, 30'h2F0, 1);
    check("tmo_next_err", {31'd0, err}, 32'd0);

    // Source pointer wraps at the top of the word space.
    issue(30'h3FFF_FFFF, 30'h300, 16'd2);
    wait_done("wrap", 100);
    check("wrap_rd0", q_at(rd_q, 0), 32'h3FFF_FFFF);
    check("wrap_rd1", q_at(rd_q, 1), 32'h0000_0000);
    check("wrap_wd0", q_at(wd_q, 0), 32'hBFFF_FFFF);
    check("wrap_wd1", q_at(wd_q, 1), 32'hA000_0000);
    check("wrap_err", {31'd0, err}, 32'd0);

    // Reset during the second write aborts without a done pulse.
    issue(30'h100, 30'h210, 16'd4);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (cyc && we && ack_cnt >= 3) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_reached_w2", {31'd0, seen}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc",  {31'd0, cyc},  32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_dones", done_cnt, 32'd0);
    issue(30'h140, 30'h240, 16'd2);
    wait_done("rst_new", 100);
    check_copy("rst_new", 30'h140, 30'h240, 2);

    // start pulsed while busy with different parameters must be ignored.
    issue(30'h180, 30'h280, 16'd3);
    src_adr = 30'h1C0;
    dst_adr = 30'h2C0;
    len     = 16'd9;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        start = ~start;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("busy_start_done_seen", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge clk);
    check_copy("busy_start", 30'h180, 30'h280, 3);
    check("busy_start_dones", done_cnt, 32'd1);
    check("busy_start_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
